// File: rtl/common_types_pkg.sv
// Types shared between the memory arbiter and instruction decode.
package common_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } mem_size_t;

    localparam int MAX_DSTREAK_DEF = 4;
    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/byte_lane_align.sv
// Store lane alignment: byte strobes, lane-shifted write data and misalignment flag.
// Pure combinational, zero latency, no flow control.
module byte_lane_align
    import common_types_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] dstore,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    output logic        misalign
);

    always_comb begin
        mem_strb  = 4'b0000;
        misalign  = 1'b0;
        mem_wdata = dstore << {addr_lo, 3'b000};
        case (size)
            SZ_WORD: begin
                mem_strb = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            SZ_HALF: begin
                mem_strb = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            SZ_BYTE: mem_strb = 4'b0001 << addr_lo;
            default: mem_strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter for fetch and data; one transaction at a time, grant the cycle after request.
// Requests are held until hit/err; a stalled memory (no mem_ready) is aborted after TIMEOUT_CYC cycles.
module memory_arbiter
    import common_types_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iread,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dread,
    input  logic [1:0]  dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ierr,
    output logic        derr,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);

    arb_state_t  state;
    logic [SW-1:0] streak;
    logic [7:0]  timer;
    logic [31:0] lat_addr;
    logic        lat_wr;
    logic [3:0]  lat_strb;
    logic [31:0] lat_wdata;
    logic        mis_err_q;

    logic        d_is_wr, d_ok, grant_i, grant_d;
    logic        busy, tmo, hit;
    logic [3:0]  al_strb;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^iaddr[1:0];

    byte_lane_align u_align (
        .size      (mem_size_t'(dwrite)),
        .addr_lo   (daddr[1:0]),
        .dstore    (dstore),
        .mem_strb  (al_strb),
        .mem_wdata (al_wdata),
        .misalign  (al_mis)
    );

    // A data request is masked while its misalign error pulses, so the still-held request is not re-taken.
    assign d_is_wr = (dwrite != 2'b00);
    assign d_ok    = (dread | d_is_wr) & ~mis_err_q;
    assign grant_i = iread & (~d_ok | (streak == SW'(MAX_DSTREAK)));
    assign grant_d = d_ok & ~grant_i;

    assign busy = (state != IDLE);
    assign tmo  = busy & (timer == 8'(TIMEOUT_CYC));
    assign hit  = busy & mem_ready & ~tmo;

    assign ihit  = hit & (state == IBUSY);
    assign dhit  = hit & (state == DBUSY);
    assign iload = ihit ? mem_rdata : 32'h0;
    assign dload = dhit ? mem_rdata : 32'h0;
    assign ierr  = tmo & (state == IBUSY);
    assign derr  = (tmo & (state == DBUSY)) | mis_err_q;

    assign mem_ren   = ~tmo & ((state == IBUSY) | ((state == DBUSY) & ~lat_wr));
    assign mem_wen   = ~tmo & (state == DBUSY) & lat_wr;
    assign mem_addr  = busy ? lat_addr : 32'h0;
    assign mem_strb  = busy ? lat_strb : 4'h0;
    assign mem_wdata = mem_wen ? lat_wdata : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            streak    <= '0;
            timer     <= 8'h0;
            lat_addr  <= 32'h0;
            lat_wr    <= 1'b0;
            lat_strb  <= 4'h0;
            lat_wdata <= 32'h0;
            mis_err_q <= 1'b0;
        end else begin
            mis_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= 8'h0;
                    if (!iread)
                        streak <= '0;
                    if (grant_i) begin
                        state     <= IBUSY;
                        streak    <= '0;
                        lat_addr  <= {iaddr[31:2], 2'b00};
                        lat_wr    <= 1'b0;
                        lat_strb  <= 4'hF;
                        lat_wdata <= 32'h0;
                    end else if (grant_d) begin
                        if (d_is_wr && al_mis) begin
                            mis_err_q <= 1'b1;
                        end else begin
                            state     <= DBUSY;
                            lat_addr  <= {daddr[31:2], 2'b00};
                            lat_wr    <= d_is_wr;
                            lat_strb  <= d_is_wr ? al_strb : 4'hF;
                            lat_wdata <= d_is_wr ? al_wdata : 32'h0;
                            if (iread && streak != SW'(MAX_DSTREAK))
                                streak <= streak + SW'(1);
                        end
                    end
                end
                default: begin
                    if (tmo || mem_ready) begin
                        state <= IDLE;
                        timer <= 8'h0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised bench for memory_arbiter against a transaction-level reference model.
module tb_memory_arbiter;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iread, dread, ihit, dhit, ierr, derr;
    logic        mem_ren, mem_wen, mem_ready;
    logic [1:0]  dwrite;
    logic [3:0]  mem_strb;
    logic [31:0] iaddr, iload, daddr, dstore, dload;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          en_first;
        int          hits;
        int          errs;
        int          en_cycles;
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        ren;
        logic        wen;
    } obs_t;

    always #5 CLK = ~CLK;

    memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iread(iread), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dread(dread), .dwrite(dwrite), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit), .ierr(ierr), .derr(derr),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Expected outcome of one isolated transaction, straight from the access rules.
    function automatic obs_t model(input int kind, input logic [1:0] sz, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [31:0] rdata, input int delay);
        obs_t o;
        int   nb, off;
        logic wr;
        o  = '{default: 0};
        wr = (kind >= K_STORE);
        nb = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
        off = int'(addr % 32'd4);
        if (wr && (off % nb) != 0) begin
            o.errs = 1;
            return o;
        end
        o.en_first  = 1;
        o.hits      = 1;
        o.en_cycles = delay + 1;
        o.addr      = addr - 32'(off);
        o.ren       = !wr;
        o.wen       = wr;
        o.load      = rdata;
        o.strb      = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
        o.wdata     = wr ? (data << (8 * off)) : 32'h0;
        return o;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        return (sz == 2'b01) ? 32'hFF : (sz == 2'b10) ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic drop_all();
        iread  = 1'b0;
        dread  = 1'b0;
        dwrite = 2'b00;
    endtask

    // Issues one request and plays memory: mem_ready after `delay` enabled cycles; records what was seen.
    task automatic run_txn(input int kind, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int delay,
                           output obs_t o);
        o = '{default: 0};
        @(negedge CLK);
        case (kind)
            K_FETCH: begin iread = 1'b1; iaddr = addr; end
            K_LOAD:  begin dread = 1'b1; daddr = addr; end
            default: begin
                dwrite = sz; dread = (kind == K_BOTH); daddr = addr; dstore = data;
            end
        endcase
        mem_ready = 1'b0;
        mem_rdata = rdata;
        for (int i = 0; i < delay + 5; i++) begin
            @(negedge CLK);
            if (mem_ren || mem_wen) begin
                if (o.en_cycles == 0) begin
                    o.en_first = (i == 0) ? 1 : 0;
                    o.addr  = mem_addr;
                    o.strb  = mem_strb;
                    o.wdata = mem_wdata;
                    o.ren   = mem_ren;
                    o.wen   = mem_wen;
                end
                mem_ready = (o.en_cycles == delay);
                o.en_cycles++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (ihit || dhit) begin
                o.hits++;
                o.load = ihit ? iload : dload;
                drop_all();
            end
            if (ierr || derr) begin
                o.errs++;
                drop_all();
            end
        end
        drop_all();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        iread = 1'b1; dread = 1'b1; dwrite = 2'b11;
        mem_ready = 1'b1; mem_rdata = $urandom | 32'h1;
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++;
        if ({ihit, dhit, ierr, derr} !== 4'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 0000", {ihit, dhit, ierr, derr});
        end
        n_cmp++;
        if ({mem_ren, mem_wen} !== 2'b00) begin
            n_bad++; $display("FAIL reset_enables: got %b want 00", {mem_ren, mem_wen});
        end
        n_cmp++;
        if ({iload, dload} !== 64'h0) begin
            n_bad++; $display("FAIL reset_loads: got %h %h want 0", iload, dload);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_strb} !== 68'h0) begin
            n_bad++; $display("FAIL reset_bus: got %h %h %b want 0", mem_addr, mem_wdata, mem_strb);
        end
        drop_all();
        mem_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fetch();
        obs_t o, e;
        logic [31:0] a, rd;
        int dl;
        run_txn(K_FETCH, 2'b00, 32'h100, 32'h0, 32'h0050_0093, 2, o);
        n_cmp++;
        if (o.hits !== 1 || o.load !== 32'h0050_0093 || o.en_cycles !== 3 || o.en_first !== 1) begin
            n_bad++;
            $display("FAIL fetch_directed: hits=%0d load=%h en_cycles=%0d first=%0d, want 1 00500093 3 1",
                     o.hits, o.load, o.en_cycles, o.en_first);
        end
        n_cmp++;
        if (o.addr !== 32'h100 || o.ren !== 1'b1 || o.wen !== 1'b0 || o.strb !== 4'hF) begin
            n_bad++;
            $display("FAIL fetch_bus: addr=%h ren=%b wen=%b strb=%b, want 00000100 1 0 1111",
                     o.addr, o.ren, o.wen, o.strb);
        end
        for (int k = 0; k < 10; k++) begin
            a  = $urandom & 32'h0000_FFFF;
            rd = $urandom;
            dl = $urandom_range(0, 3);
            e  = model(K_FETCH, 2'b00, a, 32'h0, rd, dl);
            run_txn(K_FETCH, 2'b00, a, 32'h0, rd, dl, o);
            n_cmp++;
            if (o.hits !== e.hits || o.load !== e.load || o.en_cycles !== e.en_cycles || o.addr !== e.addr) begin
                n_bad++;
                $display("FAIL fetch_rand%0d: hits=%0d load=%h en=%0d addr=%h, want %0d %h %0d %h",
                         k, o.hits, o.load, o.en_cycles, o.addr, e.hits, e.load, e.en_cycles, e.addr);
            end
        end
    endtask

    task automatic test_byte_store();
        obs_t o;
        run_txn(K_STORE, 2'b01, 32'h203, 32'hAB, 32'h0, 1, o);
        n_cmp++;
        if (o.strb !== 4'b1000 || o.wdata !== 32'hAB00_0000 || o.addr !== 32'h200 ||
            o.wen !== 1'b1 || o.ren !== 1'b0 || o.hits !== 1) begin
            n_bad++;
            $display("FAIL byte_store: strb=%b wdata=%h addr=%h wen=%b ren=%b hits=%0d, want 1000 ab000000 00000200 1 0 1",
                     o.strb, o.wdata, o.addr, o.wen, o.ren, o.hits);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(K_STORE, 2'b11, 32'h202, 32'h1234_5678, 32'h0, 0, o);
        n_cmp++;
        if (o.errs !== 1 || o.hits !== 0 || o.en_cycles !== 0) begin
            n_bad++;
            $display("FAIL misaligned_word: errs=%0d hits=%0d en_cycles=%0d, want 1 0 0",
                     o.errs, o.hits, o.en_cycles);
        end
        run_txn(K_FETCH, 2'b00, 32'h40, 32'h0, 32'hCAFE_F00D, 0, o);
        n_cmp++;
        if (o.en_first !== 1 || o.hits !== 1 || o.load !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL misaligned_then_idle: first=%0d hits=%0d load=%h, want 1 1 cafef00d",
                     o.en_first, o.hits, o.load);
        end
    endtask

    task automatic test_data_random();
        obs_t o, e;
        int kind, dl;
        logic [1:0] sz;
        logic [31:0] a, d, rd;
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(K_LOAD, K_BOTH);
            sz   = 2'($urandom_range(1, 3));
            a    = $urandom & 32'h0000_0FFF;
            d    = $urandom & size_mask(sz);
            rd   = $urandom;
            dl   = $urandom_range(0, 3);
            e    = model(kind, sz, a, d, rd, dl);
            run_txn(kind, sz, a, d, rd, dl, o);
            n_cmp++;
            if (o.hits !== e.hits || o.errs !== e.errs || o.en_first !== e.en_first || o.en_cycles !== e.en_cycles) begin
                n_bad++;
                $display("FAIL data_rand%0d kind=%0d sz=%b addr=%h: hits=%0d errs=%0d first=%0d en=%0d, want %0d %0d %0d %0d",
                         k, kind, sz, a, o.hits, o.errs, o.en_first, o.en_cycles,
                         e.hits, e.errs, e.en_first, e.en_cycles);
            end
            if (e.hits == 1) begin
                n_cmp++;
                if (o.addr !== e.addr || o.strb !== e.strb || o.ren !== e.ren || o.wen !== e.wen ||
                    (e.wen && o.wdata !== e.wdata) || (e.ren && o.load !== e.load)) begin
                    n_bad++;
                    $display("FAIL data_bus%0d kind=%0d: addr=%h strb=%b ren=%b wen=%b wdata=%h load=%h, want %h %b %b %b %h %h",
                             k, kind, o.addr, o.strb, o.ren, o.wen, o.wdata, o.load,
                             e.addr, e.strb, e.ren, e.wen, e.wdata, e.load);
                end
            end
        end
    endtask

    task automatic test_contention();
        int got[$];
        int both, run, exp_k, act;
        both = 0;
        @(negedge CLK);
        iread = 1'b1; iaddr = 32'h400;
        dread = 1'b1; daddr = 32'h800;
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            @(negedge CLK);
            #1;
            if (ihit && dhit) both++;
            if (ihit) got.push_back(1);
            if (dhit) got.push_back(0);
        end
        @(negedge CLK);
        drop_all();
        repeat (3) @(negedge CLK);
        mem_ready = 1'b0;
        n_cmp++;
        if (both !== 0) begin
            n_bad++; $display("FAIL contention_dual_hit: got %0d want 0", both);
        end
        run = 0;
        for (int g = 0; g < 10; g++) begin
            exp_k = (run == 4) ? 1 : 0;
            run   = exp_k ? 0 : run + 1;
            act   = (g < got.size()) ? got[g] : -1;
            n_cmp++;
            if (act !== exp_k) begin
                n_bad++;
                $display("FAIL contention_grant%0d: got %0d want %0d (1=fetch 0=data)", g, act, exp_k);
            end
        end
    endtask

    task automatic test_timeout();
        int en_cyc, errs, wrong;
        logic err_en;
        for (int kind = 0; kind < 2; kind++) begin
            en_cyc = 0; errs = 0; wrong = 0; err_en = 1'b1;
            @(negedge CLK);
            if (kind == 0) begin iread = 1'b1; iaddr = 32'h600; end
            else           begin dread = 1'b1; daddr = 32'h604; end
            mem_ready = 1'b0;
            for (int c = 0; c < 270; c++) begin
                @(negedge CLK);
                #1;
                if (mem_ren) en_cyc++;
                if (kind == 0 ? derr : ierr) wrong++;
                if (ierr || derr) begin
                    errs++;
                    err_en = mem_ren;
                    drop_all();
                end
            end
            drop_all();
            n_cmp++;
            if (en_cyc !== 255) begin
                n_bad++; $display("FAIL timeout%0d_ren_cycles: got %0d want 255", kind, en_cyc);
            end
            n_cmp++;
            if (errs !== 1 || wrong !== 0) begin
                n_bad++; $display("FAIL timeout%0d_err: got %0d pulses (%0d wrong line) want 1 (0)", kind, errs, wrong);
            end
            n_cmp++;
            if (err_en !== 1'b0) begin
                n_bad++; $display("FAIL timeout%0d_ren_at_err: got %b want 0", kind, err_en);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic wen_before;
        @(negedge CLK);
        dwrite = 2'b11; daddr = 32'h300; dstore = $urandom;
        mem_ready = 1'b0;
        repeat (3) @(negedge CLK);
        wen_before = mem_wen;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (wen_before !== 1'b1 || {mem_wen, mem_ren} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_async: wen before=%b after wen/ren=%b%b, want 1 then 00",
                     wen_before, mem_wen, mem_ren);
        end
        drop_all();
        @(negedge CLK);
        RST = 1'b0;
        run_txn(K_LOAD, 2'b00, 32'h300, 32'h0, 32'h0BAD_BEEF, 1, o);
        n_cmp++;
        if (o.en_first !== 1 || o.hits !== 1 || o.load !== 32'h0BAD_BEEF || o.ren !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_regrant: first=%0d hits=%0d load=%h ren=%b, want 1 1 0badbeef 1",
                     o.en_first, o.hits, o.load, o.ren);
        end
    endtask

    initial begin
        RST = 1'b1;
        iread = 1'b0; iaddr = 32'h0;
        dread = 1'b0; dwrite = 2'b00; daddr = 32'h0; dstore = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_byte_store();
        test_misaligned();
        test_data_random();
        test_contention();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
